// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the line and beat geometry of the L2 to memory path.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int L2_LINESIZE    = 128;
    localparam int MEM_BEAT_WIDTH = 64;

    function automatic int beats_per_line(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

    // Clears the byte-offset bits so the address names a whole line.
    function automatic lc3b_word line_align(input lc3b_word addr, input int line_w);
        return addr & ~lc3b_word'((line_w / 8) - 1);
    endfunction

endpackage

// File: rtl/pmem_burst_responder.sv
// Moves one L2 line per pmem request as a burst of narrow beats over a
// valid/ready memory bus; a single transaction is in flight at a time.
//
// state   | meaning
// S_IDLE  | waiting for pmem_read / pmem_write
// S_CMD   | burst command offered on the bus
// S_WDATA | sending write beats
// S_WACK  | waiting for the write-complete ack
// S_RDATA | collecting read beats
// S_RESP  | one-cycle pmem_resp pulse
module pmem_burst_responder
    import lc3b_types::*;
#(
    parameter int LINESIZE   = L2_LINESIZE,
    parameter int BEAT_WIDTH = MEM_BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [15:0]           pmem_address,
    input  logic [LINESIZE-1:0]   pmem_wdata,
    output logic [LINESIZE-1:0]   pmem_rdata,
    output logic                  pmem_resp,
    output logic                  bus_cmd_valid,
    input  logic                  bus_cmd_ready,
    output logic                  bus_cmd_write,
    output logic [15:0]           bus_cmd_addr,
    output logic [BEAT_WIDTH-1:0] bus_wdata,
    output logic                  bus_wvalid,
    input  logic                  bus_wready,
    input  logic                  bus_bvalid,
    input  logic [BEAT_WIDTH-1:0] bus_rdata,
    input  logic                  bus_rvalid
);

    localparam int BEATS = beats_per_line(LINESIZE, BEAT_WIDTH);
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  last_beat;
    logic                  op_write;
    lc3b_word              addr_q;
    logic [BEAT_WIDTH-1:0] line_buf [BEATS];
    logic [LINESIZE-1:0]   rdata_q;
    logic [LINESIZE-1:0]   rd_line;

    assign idx        = cnt[IDX_W-1:0];
    assign last_beat  = (cnt == LAST_BEAT);
    assign pmem_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus_cmd_valid = 1'b0;
        bus_cmd_write = 1'b0;
        bus_cmd_addr  = '0;
        bus_wvalid    = 1'b0;
        bus_wdata     = '0;
        pmem_resp     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pmem_read || pmem_write) begin
                    state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                bus_cmd_valid = 1'b1;
                bus_cmd_write = op_write;
                bus_cmd_addr  = addr_q;
                if (bus_cmd_ready) begin
                    state_nxt = op_write ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                bus_wvalid = 1'b1;
                bus_wdata  = line_buf[idx];
                if (bus_wready && last_beat) begin
                    state_nxt = S_WACK;
                end
            end
            S_WACK: begin
                if (bus_bvalid) begin
                    state_nxt = S_RESP;
                end
            end
            S_RDATA: begin
                if (bus_rvalid && last_beat) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                pmem_resp = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line as it will look once the beat arriving this cycle lands, so the
    // final beat can go straight into pmem_rdata without an extra cycle.
    always_comb begin
        rd_line = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (IDX_W'(i) == idx) begin
                rd_line[i*BEAT_WIDTH +: BEAT_WIDTH] = bus_rdata;
            end else begin
                rd_line[i*BEAT_WIDTH +: BEAT_WIDTH] = line_buf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < BEATS; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (pmem_read || pmem_write) begin
                        op_write <= pmem_write;
                        addr_q   <= line_align(pmem_address, LINESIZE);
                        cnt      <= '0;
                        for (int i = 0; i < BEATS; i++) begin
                            line_buf[i] <= pmem_wdata[i*BEAT_WIDTH +: BEAT_WIDTH];
                        end
                    end
                end
                S_CMD: begin
                    if (bus_cmd_ready) begin
                        cnt <= '0;
                    end
                end
                S_WDATA: begin
                    if (bus_wready) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RDATA: begin
                    if (bus_rvalid) begin
                        line_buf[idx] <= bus_rdata;
                        cnt           <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            rdata_q <= rd_line;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Scoreboard bench: an L2-side driver, a memory-side bus model and a response
// monitor around a two-beat build, plus a short run on a single-beat build.
module tb_pmem_burst_responder;
    import lc3b_types::*;

    localparam int LW = 128;
    localparam int BW = 64;
    localparam int NB = LW / BW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           pmem_read, pmem_write;
    logic [15:0]    pmem_address;
    logic [LW-1:0]  pmem_wdata, pmem_rdata;
    logic           pmem_resp;
    logic           bus_cmd_valid, bus_cmd_ready, bus_cmd_write;
    logic [15:0]    bus_cmd_addr;
    logic [BW-1:0]  bus_wdata, bus_rdata;
    logic           bus_wvalid, bus_wready, bus_bvalid, bus_rvalid;

    logic           pmem_read_1, pmem_write_1, pmem_resp_1;
    logic [15:0]    pmem_address_1, bus_cmd_addr_1;
    logic [LW-1:0]  pmem_wdata_1, pmem_rdata_1, bus_wdata_1, bus_rdata_1;
    logic           bus_cmd_valid_1, bus_cmd_ready_1, bus_cmd_write_1;
    logic           bus_wvalid_1, bus_wready_1, bus_bvalid_1, bus_rvalid_1;

    pmem_burst_responder #(.LINESIZE(LW), .BEAT_WIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready),
        .bus_cmd_write(bus_cmd_write), .bus_cmd_addr(bus_cmd_addr),
        .bus_wdata(bus_wdata), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
        .bus_bvalid(bus_bvalid), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
    );

    pmem_burst_responder #(.LINESIZE(LW), .BEAT_WIDTH(LW)) dut_1beat (
        .clk(clk), .reset(reset),
        .pmem_read(pmem_read_1), .pmem_write(pmem_write_1), .pmem_address(pmem_address_1),
        .pmem_wdata(pmem_wdata_1), .pmem_rdata(pmem_rdata_1), .pmem_resp(pmem_resp_1),
        .bus_cmd_valid(bus_cmd_valid_1), .bus_cmd_ready(bus_cmd_ready_1),
        .bus_cmd_write(bus_cmd_write_1), .bus_cmd_addr(bus_cmd_addr_1),
        .bus_wdata(bus_wdata_1), .bus_wvalid(bus_wvalid_1), .bus_wready(bus_wready_1),
        .bus_bvalid(bus_bvalid_1), .bus_rdata(bus_rdata_1), .bus_rvalid(bus_rvalid_1)
    );

    typedef struct { logic wr; logic [15:0] addr; } cmd_t;
    typedef struct { logic rd; logic [LW-1:0] data; } rsp_t;

    cmd_t          cmd_q[$];
    rsp_t          rsp_q[$];
    logic [LW-1:0] wline_q[$];
    logic [LW-1:0] bus_mem [logic [15:0]];
    logic [LW-1:0] ref_mem [logic [15:0]];
    logic [LW-1:0] last_rd = '0;

    bit auto_bus    = 1'b1;
    bit zero_wait   = 1'b0;
    int fixed_stall = -1;
    int n_checks    = 0;
    int n_pass      = 0;

    function automatic logic [LW-1:0] init_line(input logic [15:0] a);
        return {4{a, ~a}};
    endfunction

    function automatic logic [LW-1:0] bus_mem_get(input logic [15:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_line(a);
    endfunction

    function automatic logic [LW-1:0] ref_get(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event not seen within its bound", name);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // mode: 0 read, 1 write, 2 read and write together (behaves as write)
    task automatic l2_txn(input int mode, input logic [15:0] addr, input logic [LW-1:0] wd,
                          input int gap, output int lat);
        logic [15:0] al;
        logic        wr;
        logic [LW-1:0] exp;
        al = addr & 16'hFFF0;
        wr = (mode != 0);
        @(negedge clk);
        repeat (gap) @(negedge clk);
        cmd_q.push_back('{wr, al});
        if (wr) begin
            wline_q.push_back(wd);
            ref_mem[al] = wd;
            rsp_q.push_back('{1'b0, last_rd});
        end else begin
            exp = ref_get(al);
            last_rd = exp;
            rsp_q.push_back('{1'b1, exp});
        end
        pmem_read    = (mode != 1);
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                pmem_address = 16'($urandom);
                pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end
        end while (!pmem_resp && lat < 400);
        if (!pmem_resp) begin
            fail("pmem_resp_timeout");
            finish_run();
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    task automatic monitor();
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!reset && pmem_resp) begin
                if (rsp_q.size() == 0) begin
                    fail("unexpected_pmem_resp");
                end else begin
                    r = rsp_q.pop_front();
                    check(r.rd ? "read_line" : "rdata_hold_on_write", pmem_rdata, r.data);
                end
            end
        end
    endtask

    task automatic bus_model();
        logic [15:0]   c_addr;
        logic          c_wr;
        logic [LW-1:0] line;
        cmd_t          exp_c;
        int            stall, k, guard, d;
        bit            wtog;
        forever begin
            @(negedge clk);
            if (!auto_bus) continue;
            bus_cmd_ready = 1'b0;
            bus_rvalid    = 1'b0;
            bus_bvalid    = 1'b0;
            bus_wready    = 1'b0;
            bus_rdata     = {$urandom, $urandom};
            if (reset) continue;
            if (!bus_cmd_valid) begin
                if (!zero_wait && $urandom_range(0, 3) == 0) begin
                    bus_rvalid = 1'($urandom);
                    bus_bvalid = 1'($urandom);
                end
                continue;
            end
            c_addr = bus_cmd_addr;
            c_wr   = bus_cmd_write;
            stall  = (fixed_stall >= 0) ? fixed_stall : (zero_wait ? 0 : $urandom_range(0, 3));
            repeat (stall) begin
                bus_rvalid = 1'($urandom);
                bus_bvalid = 1'($urandom);
                bus_rdata  = {$urandom, $urandom};
                @(negedge clk);
                check("cmd_stable", {bus_cmd_valid, bus_cmd_write, bus_cmd_addr}, {1'b1, c_wr, c_addr});
            end
            if (cmd_q.size() == 0) begin
                fail("unexpected_bus_cmd");
            end else begin
                exp_c = cmd_q.pop_front();
                check("cmd_write", c_wr, exp_c.wr);
                check("cmd_addr", c_addr, exp_c.addr);
            end
            bus_rvalid    = 1'b0;
            bus_bvalid    = 1'b0;
            bus_cmd_ready = 1'b1;
            @(negedge clk);
            bus_cmd_ready = 1'b0;
            line  = bus_mem_get(c_addr);
            k     = 0;
            guard = 0;
            if (c_wr) begin
                wtog = 1'($urandom);
                while (k < NB && guard < 100) begin
                    bus_wready = zero_wait ? 1'b1 : wtog;
                    wtog = ~wtog;
                    if (bus_wvalid && bus_wready) begin
                        line[k*BW +: BW] = bus_wdata;
                        k++;
                    end
                    @(negedge clk);
                    guard++;
                end
                bus_wready = 1'b0;
                if (k < NB) fail("write_beats");
                check("wvalid_drop", bus_wvalid, 1'b0);
                if (wline_q.size() == 0) fail("unexpected_write_burst");
                else check("write_line", line, wline_q.pop_front());
                bus_mem[c_addr] = line;
                d = zero_wait ? 0 : $urandom_range(0, 3);
                repeat (d) begin
                    check("resp_before_bvalid", pmem_resp, 1'b0);
                    @(negedge clk);
                end
                bus_bvalid = 1'b1;
                @(negedge clk);
                bus_bvalid = 1'b0;
                check("resp_after_bvalid", pmem_resp, 1'b1);
            end else begin
                while (k < NB && guard < 100) begin
                    if (zero_wait || $urandom_range(0, 2) != 0) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = line[k*BW +: BW];
                        k++;
                    end else begin
                        bus_rvalid = 1'b0;
                        bus_rdata  = {$urandom, $urandom};
                    end
                    @(negedge clk);
                    guard++;
                end
                bus_rvalid = 1'b0;
            end
        end
    endtask

    initial begin
        int lat, nbeat;
        logic [LW-1:0] r1, w1;
        reset = 1'b1;
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
        bus_cmd_ready = 1'b0; bus_wready = 1'b0; bus_bvalid = 1'b0;
        bus_rvalid = 1'b0; bus_rdata = '0;
        r1 = {$urandom, $urandom, $urandom, $urandom};
        w1 = {$urandom, $urandom, $urandom, $urandom};
        pmem_read_1 = 1'b0; pmem_write_1 = 1'b0; pmem_address_1 = '0; pmem_wdata_1 = '0;
        bus_cmd_ready_1 = 1'b1; bus_wready_1 = 1'b1; bus_bvalid_1 = 1'b1;
        bus_rvalid_1 = 1'b1; bus_rdata_1 = r1;
        fork
            bus_model();
            monitor();
            begin
                #500000;
                fail("global_watchdog");
                finish_run();
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_outputs", {bus_cmd_valid, bus_cmd_write, bus_cmd_addr, bus_wvalid, bus_wdata, pmem_resp}, '0);
        check("reset_rdata", pmem_rdata, '0);
        check("reset_outputs_1beat", {bus_cmd_valid_1, bus_wvalid_1, pmem_resp_1, pmem_rdata_1}, '0);
        reset = 1'b0;

        // zero-wait read and write latency
        zero_wait = 1'b1;
        bus_mem[16'h1230] = {64'hBBBB_BBBB_BBBB_0002, 64'hAAAA_AAAA_AAAA_0001};
        ref_mem[16'h1230] = {64'hBBBB_BBBB_BBBB_0002, 64'hAAAA_AAAA_AAAA_0001};
        l2_txn(0, 16'h1234, '0, 0, lat);
        check("read_latency", lat, 4);
        l2_txn(1, 16'h2200, {$urandom, $urandom, $urandom, $urandom}, 0, lat);
        check("write_latency", lat, 5);

        // stalled command, toggling wready
        zero_wait   = 1'b0;
        fixed_stall = 3;
        l2_txn(1, 16'h8010, 128'hFEDCBA9876543210_0123456789ABCDEF, 0, lat);
        fixed_stall = -1;

        // back-to-back read, write, read
        l2_txn(0, 16'h801F, '0, 0, lat);
        l2_txn(1, 16'h3000, {$urandom, $urandom, $urandom, $urandom}, 0, lat);
        l2_txn(0, 16'h8012, '0, 0, lat);
        repeat (10) @(negedge clk);
        check("no_extra_cmd", bus_cmd_valid, 1'b0);
        check("no_pending_cmds", cmd_q.size(), 0);

        // spurious rvalid/bvalid while idle
        auto_bus = 1'b0;
        @(negedge clk);
        repeat (6) begin
            bus_rvalid = 1'b1;
            bus_bvalid = 1'b1;
            bus_rdata  = {$urandom, $urandom};
            @(negedge clk);
            check("spurious_no_resp", pmem_resp, 1'b0);
            check("spurious_rdata_kept", pmem_rdata, last_rd);
        end
        bus_rvalid = 1'b0;
        bus_bvalid = 1'b0;

        // reset after the first read beat
        pmem_read = 1'b1;
        pmem_address = 16'h4455;
        @(negedge clk);
        check("manual_cmd_valid", bus_cmd_valid, 1'b1);
        bus_cmd_ready = 1'b1;
        @(negedge clk);
        bus_cmd_ready = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 64'hDEAD_BEEF_0BAD_0BAD;
        @(negedge clk);
        bus_rvalid = 1'b0;
        pmem_read  = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midburst_reset_outputs", {bus_cmd_valid, bus_cmd_write, bus_cmd_addr, bus_wvalid, bus_wdata, pmem_resp}, '0);
        check("midburst_reset_rdata", pmem_rdata, '0);
        last_rd  = '0;
        auto_bus = 1'b1;
        l2_txn(0, 16'h4455, '0, 0, lat);

        // randomized traffic over a few lines
        for (int t = 0; t < 40; t++) begin
            l2_txn(($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1)),
                   16'h5000 | 16'($urandom_range(0, 7) << 4) | 16'($urandom_range(0, 15)),
                   {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2), lat);
        end

        // single-beat build: ready/valid inputs held high, ignored outside their states
        @(negedge clk);
        pmem_read_1 = 1'b1;
        pmem_address_1 = 16'h2345;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus_cmd_valid_1) check("b1_cmd", {bus_cmd_write_1, bus_cmd_addr_1}, {1'b0, 16'h2340});
        end while (!pmem_resp_1 && lat < 20);
        pmem_read_1 = 1'b0;
        check("b1_read_latency", lat, 3);
        check("b1_read_line", pmem_rdata_1, r1);
        @(negedge clk);
        pmem_write_1 = 1'b1;
        pmem_wdata_1 = w1;
        lat = 0;
        nbeat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus_wvalid_1) begin
                nbeat++;
                check("b1_write_beat", bus_wdata_1, w1);
            end
        end while (!pmem_resp_1 && lat < 20);
        pmem_write_1 = 1'b0;
        check("b1_write_latency", lat, 4);
        check("b1_write_beats", nbeat, 1);
        check("b1_rdata_hold", pmem_rdata_1, r1);

        repeat (5) @(negedge clk);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("wline_queue_drained", wline_q.size(), 0);
        finish_run();
    end

endmodule
